// File: rtl/approx_mon_pkg.sv
// Shared state encoding, default sizes and the saturating accumulator add
// used by the approximate-multiplier error monitor.
package approx_mon_pkg;

   localparam int W_DEF         = 16;
   localparam int N_SAMPLES_DEF = 65536;
   localparam int ACC_W_DEF     = 32;
   localparam int CNT_W_DEF     = 17;
   localparam int ACC_MAX_W     = 64;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mon_state_e;

   // Returns {clamped, result}; acc_w picks the saturation point and must stay below ACC_MAX_W.
   function automatic logic [ACC_MAX_W:0] sat_add(
      input logic [ACC_MAX_W-1:0] a,
      input logic [ACC_MAX_W-1:0] b,
      input int                   acc_w
   );
      logic [ACC_MAX_W-1:0] lim;
      logic [ACC_MAX_W:0]   sum;
      lim = (ACC_MAX_W'(1) << acc_w) - ACC_MAX_W'(1);
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, lim}) begin
         return {1'b1, lim};
      end
      return {1'b0, sum[ACC_MAX_W-1:0]};
   endfunction

endpackage

// File: rtl/approx_error_monitor_if.sv
// Product-pair sample stream into the error monitor: valid/ready handshake,
// no buffering; the slave side owns in_ready.
interface approx_error_monitor_if
   import approx_mon_pkg::*;
#(
   parameter int W = W_DEF
);
   logic         in_valid;
   logic         in_ready;
   logic         in_last;
   logic [W-1:0] exact;
   logic [W-1:0] approx;

   modport master (output in_valid, exact, approx, in_last, input in_ready);
   modport slave  (input in_valid, exact, approx, in_last, output in_ready);
endinterface

// File: rtl/abs_err_stage.sv
// Stage 1 of the monitor: registers |exact - approx| and the mismatch flag, 1 cycle latency.
// Never stalls; the caller only presents a sample on an accepted handshake.
module abs_err_stage
   import approx_mon_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   input  logic [W-1:0] exact,
   input  logic [W-1:0] approx,
   output logic         out_vld,
   output logic [W-1:0] out_abs,
   output logic         out_nz
);

   logic         vld_q, vld_d;
   logic         nz_q, nz_d;
   logic [W-1:0] abs_q, abs_d;

   always_comb begin
      vld_d = in_vld;
      abs_d = abs_q;
      nz_d  = nz_q;
      if (in_vld) begin
         // Subtracting in the larger-minus-smaller order gives the magnitude in W bits directly.
         abs_d = (exact >= approx) ? (exact - approx) : (approx - exact);
         nz_d  = (exact != approx);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         abs_q <= '0;
         nz_q  <= 1'b0;
      end else begin
         vld_q <= vld_d;
         abs_q <= abs_d;
         nz_q  <= nz_d;
      end
   end

   assign out_vld = vld_q;
   assign out_abs = abs_q;
   assign out_nz  = nz_q;

endmodule

// File: rtl/approx_error_monitor.sv
// Accumulates error metrics of an approximate multiplier stream; metrics lag acceptance by 2 cycles.
// Accepts one sample per cycle while running (in_ready), none otherwise.
module approx_error_monitor
   import approx_mon_pkg::*;
#(
   parameter int W         = W_DEF,
   parameter int N_SAMPLES = N_SAMPLES_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   approx_error_monitor_if.slave s_if,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    sample_count,
   output logic [CNT_W-1:0]    err_count,
   output logic [ACC_W-1:0]    sum_abs_err,
   output logic [W-1:0]        max_abs_err,
   output logic                sum_sat
);

   mon_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [W-1:0]     max_q, max_d;
   logic             sat_q, sat_d;

   logic             clear;
   logic             accept;
   logic             last_hit;
   logic [CNT_W-1:0] cnt_inc;
   logic             s1_vld;
   logic             s1_nz;
   logic [W-1:0]     s1_abs;
   logic [ACC_MAX_W:0] sat_res;
   logic             unused_sat_hi;

   assign s_if.in_ready = (state_q == RUN);
   assign accept        = s_if.in_valid && s_if.in_ready;
   assign cnt_inc       = cnt_q + CNT_W'(1);
   assign last_hit      = s_if.in_last || (cnt_inc == CNT_W'(N_SAMPLES));

   abs_err_stage #(.W(W)) u_stage1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (accept),
      .exact   (s_if.exact),
      .approx  (s_if.approx),
      .out_vld (s1_vld),
      .out_abs (s1_abs),
      .out_nz  (s1_nz)
   );

   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               clear   = 1'b1;
            end
         end
         RUN: begin
            if (accept && last_hit) state_d = DRAIN;
         end
         // Stage 2 is the accumulator itself, so once stage 1 is empty the metrics are final.
         DRAIN: begin
            if (!s1_vld) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign sat_res       = sat_add(ACC_MAX_W'(sum_q), ACC_MAX_W'(s1_abs), ACC_W);
   assign unused_sat_hi = ^sat_res[ACC_MAX_W-1:ACC_W];

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      sum_d = sum_q;
      max_d = max_q;
      sat_d = sat_q;
      if (clear) begin
         cnt_d = '0;
         err_d = '0;
         sum_d = '0;
         max_d = '0;
         sat_d = 1'b0;
      end else begin
         if (accept) cnt_d = cnt_inc;
         if (s1_vld) begin
            err_d = err_q + CNT_W'(s1_nz);
            sum_d = sat_res[ACC_W-1:0];
            sat_d = sat_q | sat_res[ACC_MAX_W];
            if (s1_abs > max_q) max_d = s1_abs;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= '0;
         sum_q   <= '0;
         max_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         sum_q   <= sum_d;
         max_q   <= max_d;
         sat_q   <= sat_d;
      end
   end

   assign busy         = (state_q == RUN) || (state_q == DRAIN);
   assign done         = (state_q == DONE);
   assign sample_count = cnt_q;
   assign err_count    = err_q;
   assign sum_abs_err  = sum_q;
   assign max_abs_err  = max_q;
   assign sum_sat      = sat_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: three instances (default, 20-bit accumulator, 16-sample limit)
// share one stimulus stream; a run-level reference model predicts the selected instance.
module tb_approx_error_monitor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [15:0] exact = '0;
   logic [15:0] approx = '0;

   always #5 clk = ~clk;

   approx_error_monitor_if #(.W(16)) if0 ();
   approx_error_monitor_if #(.W(16)) if1 ();
   approx_error_monitor_if #(.W(16)) if2 ();

   assign if0.in_valid = in_valid; assign if0.in_last = in_last;
   assign if0.exact = exact;       assign if0.approx = approx;
   assign if1.in_valid = in_valid; assign if1.in_last = in_last;
   assign if1.exact = exact;       assign if1.approx = approx;
   assign if2.in_valid = in_valid; assign if2.in_last = in_last;
   assign if2.exact = exact;       assign if2.approx = approx;

   logic        rdy_w  [3];
   logic        busy_w [3];
   logic        done_w [3];
   logic [16:0] sc_w   [3];
   logic [16:0] ec_w   [3];
   logic [31:0] sum_w  [3];
   logic [15:0] max_w  [3];
   logic        sat_w  [3];
   logic [31:0] sum0, sum2;
   logic [19:0] sum1;

   assign rdy_w[0] = if0.in_ready;
   assign rdy_w[1] = if1.in_ready;
   assign rdy_w[2] = if2.in_ready;
   assign sum_w[0] = sum0;
   assign sum_w[1] = {12'd0, sum1};
   assign sum_w[2] = sum2;

   approx_error_monitor #(.W(16), .N_SAMPLES(65536), .ACC_W(32), .CNT_W(17)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .s_if(if0),
      .busy(busy_w[0]), .done(done_w[0]), .sample_count(sc_w[0]), .err_count(ec_w[0]),
      .sum_abs_err(sum0), .max_abs_err(max_w[0]), .sum_sat(sat_w[0]));

   approx_error_monitor #(.W(16), .N_SAMPLES(65536), .ACC_W(20), .CNT_W(17)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .s_if(if1),
      .busy(busy_w[1]), .done(done_w[1]), .sample_count(sc_w[1]), .err_count(ec_w[1]),
      .sum_abs_err(sum1), .max_abs_err(max_w[1]), .sum_sat(sat_w[1]));

   approx_error_monitor #(.W(16), .N_SAMPLES(16), .ACC_W(32), .CNT_W(17)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .s_if(if2),
      .busy(busy_w[2]), .done(done_w[2]), .sample_count(sc_w[2]), .err_count(ec_w[2]),
      .sum_abs_err(sum2), .max_abs_err(max_w[2]), .sum_sat(sat_w[2]));

   int     n_chk = 0;
   int     n_err = 0;
   int     sel = 0;
   longint n_lim [3] = '{65536, 65536, 16};
   int     accw  [3] = '{32, 20, 32};

   // Reference model: what a run has accumulated, whether it is still taking samples,
   // and how many drain cycles remain before the results are published.
   bit     m_run, m_started, m_sat;
   int     m_drain;
   longint m_cnt, m_err, m_sum, m_max;

   typedef struct {
      logic [15:0] e;
      logic [15:0] a;
      longint      exp_err;
      longint      exp_abs;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_started = 0; m_sat = 0; m_drain = 0;
      m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0;
   endtask

   function automatic bit exp_done();
      return m_started && !m_run && (m_drain == 0);
   endfunction

   task automatic cyc(input bit st, input bit v, input logic [15:0] e, input logic [15:0] a,
                      input bit l);
      longint d, lim;
      bit acc, start_ok;
      start = st; in_valid = v; exact = e; approx = a; in_last = l;
      acc      = v && m_run;
      start_ok = st && !m_run && (m_drain == 0);
      lim      = (longint'(1) << accw[sel]) - 1;
      if (m_drain > 0) m_drain--;
      if (acc) begin
         m_cnt++;
         if (e != a) m_err++;
         d = (e > a) ? (longint'(e) - longint'(a)) : (longint'(a) - longint'(e));
         if (m_sum + d > lim) begin m_sum = lim; m_sat = 1; end
         else m_sum = m_sum + d;
         if (d > m_max) m_max = d;
         if (l || m_cnt == n_lim[sel]) begin m_run = 0; m_drain = 2; end
      end
      if (start_ok) begin
         m_run = 1; m_started = 1; m_sat = 0;
         m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0;
      end
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [15:0] e, input logic [15:0] a, input bit l);
      cyc(1'b0, 1'b1, e, a, l);
   endtask

   task automatic check_state(input string nm);
      chk({nm, "_rdy"},  rdy_w[sel],  m_run);
      chk({nm, "_busy"}, busy_w[sel], m_run || (m_drain > 0));
      chk({nm, "_done"}, done_w[sel], exp_done());
      chk({nm, "_sc"},   sc_w[sel],   m_cnt);
   endtask

   task automatic check_metrics(input string nm);
      chk({nm, "_done"}, done_w[sel], exp_done());
      chk({nm, "_sc"},   sc_w[sel],   m_cnt);
      chk({nm, "_ec"},   ec_w[sel],   m_err);
      chk({nm, "_sum"},  sum_w[sel],  m_sum);
      chk({nm, "_max"},  max_w[sel],  m_max);
      chk({nm, "_sat"},  sat_w[sel],  m_sat);
   endtask

   task automatic wait_done(input string nm);
      int k = 0;
      while (done_w[sel] !== 1'b1 && k < 20) begin
         cyc(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
         k++;
      end
      check_metrics(nm);
   endtask

   task automatic check_zero(input string nm, input int s);
      chk({nm, "_rdy"},  rdy_w[s],  0);
      chk({nm, "_busy"}, busy_w[s], 0);
      chk({nm, "_done"}, done_w[s], 0);
      chk({nm, "_sc"},   sc_w[s],   0);
      chk({nm, "_ec"},   ec_w[s],   0);
      chk({nm, "_sum"},  sum_w[s],  0);
      chk({nm, "_max"},  max_w[s],  0);
      chk({nm, "_sat"},  sat_w[s],  0);
   endtask

   task automatic do_reset();
      start = 0; in_valid = 0; in_last = 0;
      rst_n = 0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "simulation timeout");
   end

   initial begin
      int nacc, last_acc, first_done;
      logic [15:0] re, ra;

      tbl[0] = '{16'd100,   16'd98,    1, 2};
      tbl[1] = '{16'd50,    16'd50,    0, 0};
      tbl[2] = '{16'd7,     16'd12,    1, 5};
      tbl[3] = '{16'd65535, 16'd0,     1, 65535};
      tbl[4] = '{16'd0,     16'd65535, 1, 65535};
      tbl[5] = '{16'd0,     16'd0,     0, 0};
      tbl[6] = '{16'd1,     16'd0,     1, 1};
      tbl[7] = '{16'd32768, 16'd32767, 1, 1};

      model_reset();
      #1 rst_n = 0;
      #3;
      for (int s = 0; s < 3; s++) check_zero("reset", s);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      // Single-sample runs from the table, each started from IDLE/DONE.
      sel = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
         send(tbl[i].e, tbl[i].a, 1'b1);
         wait_done("tbl");
         chk("tbl_sc",  sc_w[0],  1);
         chk("tbl_ec",  ec_w[0],  tbl[i].exp_err);
         chk("tbl_sum", sum_w[0], tbl[i].exp_abs);
         chk("tbl_max", max_w[0], tbl[i].exp_abs);
      end

      cyc(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
      for (int k = 0; k < 256; k++) send(16'(k * 3), 16'(k * 3), k == 255);
      wait_done("ident");
      chk("ident_sc", sc_w[0], 256);
      chk("ident_ec", ec_w[0], 0);
      chk("ident_sum", sum_w[0], 0);

      cyc(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
      send(16'd100, 16'd98, 1'b0);
      send(16'd50, 16'd50, 1'b0);
      send(16'd7, 16'd12, 1'b0);
      send(16'd65535, 16'd0, 1'b1);
      wait_done("known");
      chk("known_ec", ec_w[0], 3);
      chk("known_sum", sum_w[0], 65542);
      chk("known_max", max_w[0], 65535);

      // Saturation on the 20-bit accumulator instance.
      sel = 1;
      do_reset();
      cyc(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
      for (int k = 0; k < 17; k++) send(16'd65535, 16'd0, k == 16);
      wait_done("sat");
      chk("sat_sum", sum_w[1], 1048575);
      chk("sat_flag", sat_w[1], 1);
      chk("nosat_sum", sum_w[0], 1114095);
      chk("nosat_flag", sat_w[0], 0);
      cyc(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
      chk("sat_clear", sat_w[1], 0);
      send(16'd3, 16'd1, 1'b1);
      wait_done("sat_clean");

      // Limit termination on the 16-sample instance.
      sel = 2;
      do_reset();
      cyc(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
      nacc = 0; last_acc = -100; first_done = -1;
      for (int i = 0; i < 30; i++) begin
         if (m_run) begin nacc++; last_acc = i; end
         send(16'($urandom()), 16'($urandom()), 1'b0);
         check_state("limit");
         if (done_w[2] === 1'b1 && first_done < 0) first_done = i + 1;
      end
      chk("limit_nacc", nacc, 16);
      chk("limit_done_lat", first_done - last_acc, 3);
      chk("limit_rdy", rdy_w[2], 0);
      check_metrics("limit");

      cyc(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
      for (int k = 0; k < 15; k++) send(16'(k + 9), 16'(k), 1'b0);
      send(16'd1, 16'd2, 1'b1);
      wait_done("limlast");
      for (int k = 0; k < 4; k++) send(16'd5, 16'd0, 1'b0);
      chk("limlast_sc", sc_w[2], 16);
      check_metrics("limlast_hold");

      // start pulsed mid-run is ignored.
      sel = 0;
      do_reset();
      cyc(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
      for (int k = 0; k < 5; k++) send(16'(k + 10), 16'(k), 1'b0);
      cyc(1'b1, 1'b1, 16'd20, 16'd5, 1'b0);
      for (int k = 0; k < 4; k++) send(16'(k), 16'(k), k == 3);
      wait_done("midstart");
      chk("midstart_sc", sc_w[0], 10);

      // Random valid/start/last traffic against the model.
      do_reset();
      cyc(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         re = 16'($urandom());
         ra = ($urandom_range(0, 3) == 0) ? re : 16'($urandom());
         cyc($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, re, ra,
             $urandom_range(0, 59) == 0);
         check_state("rnd");
      end
      if (m_run) send(16'd77, 16'd70, 1'b1);
      wait_done("rnd");

      // Reset in the middle of a run.
      do_reset();
      cyc(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
      for (int k = 0; k < 10; k++) send(16'(k + 7), 16'(k), 1'b0);
      in_valid = 0;
      #3 rst_n = 0;
      #1;
      check_zero("midrst", 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
      cyc(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
      cyc(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
      check_state("postrst_idle");
      cyc(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
      send(16'd9, 16'd4, 1'b0);
      send(16'd4, 16'd4, 1'b0);
      send(16'd0, 16'd3, 1'b1);
      wait_done("postrst");
      chk("postrst_sum", sum_w[0], 8);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/approx_error_monitor.md
Name: approx_error_monitor

Overview:
- Hardware consumer for multiplier product streams: takes (exact, approximate) product pairs and accumulates the error metrics of the approximate Wallace-tree variants.
- Metrics: error count, sum of absolute error, maximum absolute error, sample count.
- Sits downstream of the exhaustive A/B sweep and the parallel exact/approximate multipliers, so metrics are produced on-chip instead of from dumped text results.

Parameters:
- W, 16, product width (matches the 8x8 multiplier output S).
- N_SAMPLES, 65536, samples per run; the run ends automatically when this count is reached.
- ACC_W, 32, width of the sum-of-absolute-error accumulator.
- CNT_W, 17, width of the sample and error counters; must satisfy 2^CNT_W > N_SAMPLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE.
- in_valid  in  1  exact/approx/in_last are valid this cycle.
- in_ready  out  1  monitor accepts a sample this cycle.
- exact  in  W  exact product (reference multiplier).
- approx  in  W  approximate product under test.
- in_last  in  1  marks the final sample of a run.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; held until the next start.
- sample_count  out  CNT_W  samples accepted in the current or last run.
- err_count  out  CNT_W  samples where exact != approx.
- sum_abs_err  out  ACC_W  sum of |exact - approx|, saturating.
- max_abs_err  out  W  largest |exact - approx| seen.
- sum_sat  out  1  sticky; sum_abs_err has saturated.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=0, busy=0, done=0. All counters, accumulators and sum_sat are 0. Pipeline valid bits are 0.
- States:
  - IDLE: start -> RUN; accumulators and sum_sat are cleared on the start edge.
  - RUN: in_ready=1. A sample is accepted when in_valid && in_ready.
    - If the accepted sample has in_last=1, or sample_count+1 == N_SAMPLES, go to DRAIN on the next edge.
  - DRAIN: in_ready=0. Stay until both pipeline stages are empty (exactly 2 cycles), then go to DONE.
  - DONE: done=1; outputs hold. start -> RUN with a clear, as from IDLE.
- start while in RUN or DRAIN is ignored.
- Pipeline, stage 1 (registered):
  - diff = {0,exact} - {0,approx} in W+1 bits.
  - abs = diff negative ? -diff : diff, truncated to W bits (lossless; the magnitude is at most 2^W-1).
  - nz = (exact != approx).
- Pipeline, stage 2 (registered), on a valid stage-1 sample:
  - err_count += nz.
  - sum_abs_err += abs, saturating at 2^ACC_W-1. On saturation, sum_sat is set and stays set until the next start.
  - max_abs_err = max(max_abs_err, abs).
- sample_count increments at acceptance time, not stage 2. The other metrics lag acceptance by 2 cycles.
- Final values are guaranteed only while done=1.
- in_valid outside RUN: ignored, never counted.
- A sample accepted on the terminating cycle is counted. No sample is accepted after it.
- in_last=1 on the same cycle the N_SAMPLES limit is reached: a single termination.
- sample_count never exceeds N_SAMPLES.
- Reset mid-run: all state and outputs return to reset values immediately; in-flight samples are discarded.
- Back-to-back samples: one per cycle sustained in RUN, with no bubbles required.

Decomposition:
- Shared package approx_mon_pkg holds:
  - state enum: IDLE, RUN, DRAIN, DONE;
  - localparam defaults for W, ACC_W, CNT_W;
  - a saturating-add function for ACC_W.
- One sub-module, abs_err_stage: registered stage 1 (abs difference, nz flag, valid bit) with clk/rst_n. The top holds the FSM, counters and stage 2.

Test Plan:
- Identical streams: 256 samples with exact=approx=k*3, the last with in_last -> done=1, sample_count=256, err_count=0, sum_abs_err=0, max_abs_err=0, sum_sat=0.
- Known errors, 4 samples: (100,98), (50,50), (7,12), (65535,0) -> err_count=3, sum_abs_err=2+5+65535=65542, max_abs_err=65535.
- Saturation: ACC_W=20, 17 samples of (65535,0) -> sum_abs_err=1048575, sum_sat=1. The flag clears on the next start.
- Limit termination: N_SAMPLES=16, in_valid held high, no in_last -> exactly 16 accepted, then in_ready=0. DONE is reached 3 cycles after the 16th acceptance.
- Control robustness:
  - start pulsed mid-RUN -> no clear, counts continue.
  - in_valid toggled randomly -> counts match the accepted handshakes only.
- Reset mid-run: rst_n low after 10 samples -> all outputs 0 immediately, in the same cycle. After release, state is IDLE; a new start yields a clean run.
